// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the DCO frequency-lock controller: loop states and
// default tuning values.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MEASURE = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_STEP    = 3'd3,
        ST_SETTLE  = 3'd4
    } state_t;

    localparam int DEF_COUNT_WIDTH   = 12;
    localparam int DEF_WINDOW_CYCLES = 256;
    localparam int DEF_DEADBAND      = 1;
    localparam int DEF_STEP_SHIFT    = 2;
    localparam int DEF_MAX_STEPS     = 8;
    localparam int DEF_SETTLE_CYCLES = 16;
    localparam int DEF_LOCK_WINDOWS  = 4;

endpackage

// File: rtl/dco_tick_counter.sv
// Counts DCO ticks over a fixed window of clock cycles; windowDone flags the
// final cycle of the window so the count register holds the full total after it.
module dco_tick_counter
    import pll_ctrl_pkg::*;
#(
    parameter int COUNT_WIDTH   = DEF_COUNT_WIDTH,
    parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   run,
    input  logic                   dcoTick,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   windowDone
);

    localparam int WW = $clog2(WINDOW_CYCLES + 1);
    localparam logic [WW-1:0] LAST_CYCLE = WW'(WINDOW_CYCLES - 1);

    logic [WW-1:0]          r_win;
    logic [COUNT_WIDTH-1:0] r_count;

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            r_win   <= '0;
            r_count <= '0;
        end else if (run) begin
            r_win <= r_win + WW'(1);
            // Saturate rather than wrap so a fast DCO never reads as a slow one
            if (dcoTick && (r_count != '1)) begin
                r_count <= r_count + COUNT_WIDTH'(1);
            end
        end
    end

    assign count      = r_count;
    assign windowDone = run && (r_win == LAST_CYCLE);

endmodule

// File: rtl/dco_freq_lock_ctrl.sv
// Frequency-lock loop: measures DCO ticks per window, compares with the target
// and nudges the DCO with a bounded burst of inc/dec pulses until in band.
module dco_freq_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int COUNT_WIDTH   = DEF_COUNT_WIDTH,
    parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int DEADBAND      = DEF_DEADBAND,
    parameter int STEP_SHIFT    = DEF_STEP_SHIFT,
    parameter int MAX_STEPS     = DEF_MAX_STEPS,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int LOCK_WINDOWS  = DEF_LOCK_WINDOWS
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          dcoTick,
    input  logic [COUNT_WIDTH-1:0]        targetCount,
    output logic                          inc,
    output logic                          dec,
    output logic                          locked,
    output logic signed [COUNT_WIDTH:0]   lastError
);

    localparam int EW = COUNT_WIDTH + 1;
    localparam int SW = $clog2(MAX_STEPS + 1);
    localparam int LW = $clog2(LOCK_WINDOWS + 1);
    localparam int TW = $clog2(SETTLE_CYCLES + 1);

    state_t          r_state, w_state_next;
    logic            r_inc, w_inc_next;
    logic            r_dec, w_dec_next;
    logic            r_locked, w_locked_next;
    logic            r_dir_inc, w_dir_inc_next;
    logic            r_phase, w_phase_next;
    logic [EW-1:0]   r_last_error, w_last_error_next;
    logic [SW-1:0]   r_steps, w_steps_next;
    logic [LW-1:0]   r_inband, w_inband_next;
    logic [TW-1:0]   r_settle, w_settle_next;

    logic [COUNT_WIDTH-1:0] w_count;
    logic                   w_window_done;
    logic                   w_clear;
    logic                   w_run;
    logic [EW-1:0]          w_err;
    logic [EW-1:0]          w_abs;
    logic [EW-1:0]          w_raw_steps;
    logic [SW-1:0]          w_steps_clamped;
    logic                   w_in_band;
    logic [LW-1:0]          w_inband_sat;

    assign w_run   = (r_state == ST_MEASURE);
    assign w_clear = !w_run;

    dco_tick_counter #(
        .COUNT_WIDTH   (COUNT_WIDTH),
        .WINDOW_CYCLES (WINDOW_CYCLES)
    ) u_tick_counter (
        .clock      (clock),
        .reset      (reset),
        .clear      (w_clear),
        .run        (w_run),
        .dcoTick    (dcoTick),
        .count      (w_count),
        .windowDone (w_window_done)
    );

    // Error math is one bit wider than the count so the difference never overflows
    assign w_err           = {1'b0, targetCount} - {1'b0, w_count};
    assign w_abs           = w_err[EW-1] ? (EW'(0) - w_err) : w_err;
    assign w_in_band       = (w_abs <= EW'(DEADBAND));
    assign w_raw_steps     = (w_abs >> STEP_SHIFT) + EW'(1);
    assign w_steps_clamped = (w_raw_steps > EW'(MAX_STEPS)) ? SW'(MAX_STEPS) : SW'(w_raw_steps);
    assign w_inband_sat    = (r_inband < LW'(LOCK_WINDOWS)) ? (r_inband + LW'(1)) : r_inband;

    always_comb begin
        w_state_next      = r_state;
        w_inc_next        = 1'b0;
        w_dec_next        = 1'b0;
        w_locked_next     = r_locked;
        w_dir_inc_next    = r_dir_inc;
        w_phase_next      = r_phase;
        w_last_error_next = r_last_error;
        w_steps_next      = r_steps;
        w_inband_next     = r_inband;
        w_settle_next     = r_settle;

        case (r_state)
            ST_IDLE: begin
                w_locked_next = 1'b0;
                if (enable) w_state_next = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (w_window_done) w_state_next = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                w_last_error_next = w_err;
                if (w_in_band) begin
                    w_inband_next = w_inband_sat;
                    w_locked_next = (w_inband_sat == LW'(LOCK_WINDOWS));
                    w_state_next  = ST_MEASURE;
                end else begin
                    w_inband_next  = '0;
                    w_locked_next  = 1'b0;
                    w_steps_next   = w_steps_clamped;
                    w_dir_inc_next = ~w_err[EW-1];
                    w_inc_next     = ~w_err[EW-1];
                    w_dec_next     = w_err[EW-1];
                    w_phase_next   = 1'b0;
                    w_state_next   = ST_STEP;
                end
            end
            ST_STEP: begin
                // phase 0 is the high cycle of a pulse, phase 1 its low cycle
                if (!r_phase) begin
                    w_phase_next = 1'b1;
                    w_steps_next = r_steps - SW'(1);
                end else if (r_steps == '0) begin
                    w_settle_next = '0;
                    w_state_next  = ST_SETTLE;
                end else begin
                    w_inc_next   = r_dir_inc;
                    w_dec_next   = ~r_dir_inc;
                    w_phase_next = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (r_settle == TW'(SETTLE_CYCLES - 1)) begin
                    w_state_next = ST_MEASURE;
                end else begin
                    w_settle_next = r_settle + TW'(1);
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        if (!enable) begin
            w_state_next  = ST_IDLE;
            w_inc_next    = 1'b0;
            w_dec_next    = 1'b0;
            w_locked_next = 1'b0;
            w_inband_next = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_inc        <= 1'b0;
            r_dec        <= 1'b0;
            r_locked     <= 1'b0;
            r_dir_inc    <= 1'b0;
            r_phase      <= 1'b0;
            r_last_error <= '0;
            r_steps      <= '0;
            r_inband     <= '0;
            r_settle     <= '0;
        end else begin
            r_state      <= w_state_next;
            r_inc        <= w_inc_next;
            r_dec        <= w_dec_next;
            r_locked     <= w_locked_next;
            r_dir_inc    <= w_dir_inc_next;
            r_phase      <= w_phase_next;
            r_last_error <= w_last_error_next;
            r_steps      <= w_steps_next;
            r_inband     <= w_inband_next;
            r_settle     <= w_settle_next;
        end
    end

    assign inc       = r_inc;
    assign dec       = r_dec;
    assign locked    = r_locked;
    assign lastError = $signed(r_last_error);

endmodule

// File: tb/tb_dco_freq_lock_ctrl.sv
// Bench for dco_freq_lock_ctrl: a table of measurement windows with expected
// error/lock/pulse bursts, plus hand sequences for enable drop and reset.
module tb_dco_freq_lock_ctrl;

    logic               clock = 1'b0;
    logic               reset;
    logic               enable;
    logic               dcoTick;
    logic [11:0]        targetCount;
    logic               inc;
    logic               dec;
    logic               locked;
    logic signed [12:0] lastError;

    int     n_tests = 0;
    int     n_fail  = 0;
    longint cyc     = 0;

    typedef struct {
        bit     is_inc;
        longint cyc;
    } pulse_t;

    typedef struct {
        int mode;       // 0: tick on the first nticks cycles, 1: tick every 2nd cycle
        int nticks;
        int target;
        int exp_err;
        int exp_steps;
        bit exp_inc;
        bit exp_locked;
    } vec_t;

    pulse_t exp_q[$];
    pulse_t mon_e;
    vec_t   vecs[18];
    longint base;

    dco_freq_lock_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .dcoTick     (dcoTick),
        .targetCount (targetCount),
        .inc         (inc),
        .dec         (dec),
        .locked      (locked),
        .lastError   (lastError)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [11:0] rnd_tgt();
        return 12'($urandom_range(0, 4095));
    endfunction

    // Drives one cycle's inputs and returns just after the next rising edge.
    task automatic cycle_step(input logic tick, input logic [11:0] tgt);
        dcoTick     = tick;
        targetCount = tgt;
        @(posedge clock);
        #1;
    endtask

    // Called at the first MEASURE cycle; returns at the cycle after COMPUTE.
    task automatic run_measure(input int mode, input int n, input int tgt);
        for (int i = 0; i < 256; i++) begin
            cycle_step((mode == 1) ? (i % 2 == 1) : (i < n), rnd_tgt());
        end
        cycle_step(1'b1, 12'(tgt));
    endtask

    task automatic run_window(input vec_t v, input int idx);
        longint b;
        run_measure(v.mode, v.nticks, v.target);
        b = cyc;
        for (int k = 0; k < v.exp_steps; k++) begin
            exp_q.push_back('{is_inc: v.exp_inc, cyc: b + 2 * k});
        end
        check("lastError", longint'(lastError), v.exp_err);
        check("locked", longint'(locked), v.exp_locked);
        if (v.exp_steps > 0) begin
            for (int j = 0; j < 2 * v.exp_steps + 16; j++) cycle_step(1'b1, rnd_tgt());
        end
        check("missing_pulses", exp_q.size(), 0);
        $display("[TB] window %0d: target=%0d ticks=%0d lastError=%0d locked=%0b steps=%0d",
                 idx, v.target, (v.mode == 1) ? 128 : v.nticks, lastError, locked, v.exp_steps);
    endtask

    // Scoreboard side: every pulse seen must match the next expected one.
    always @(negedge clock) begin
        if (inc === 1'b1 || dec === 1'b1) begin
            check("inc_dec_exclusive", longint'(inc & dec), 0);
            check("pulse_expected", longint'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("pulse_dir", longint'(inc), longint'(mon_e.is_inc));
                check("pulse_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        vecs[0]  = '{1, 128, 100, -28, 8, 1'b0, 1'b0};
        vecs[1]  = '{0, 103, 100,  -3, 1, 1'b0, 1'b0};
        vecs[2]  = '{0,   0, 100, 100, 8, 1'b1, 1'b0};
        vecs[3]  = '{0, 100, 100,   0, 0, 1'b0, 1'b0};
        vecs[4]  = '{0, 100, 100,   0, 0, 1'b0, 1'b0};
        vecs[5]  = '{0, 101, 100,  -1, 0, 1'b0, 1'b0};
        vecs[6]  = '{0,  99, 100,   1, 0, 1'b0, 1'b1};
        vecs[7]  = '{0, 100, 100,   0, 0, 1'b0, 1'b1};
        vecs[8]  = '{0,  97, 100,   3, 1, 1'b1, 1'b0};
        vecs[9]  = '{0,  98, 100,   2, 1, 1'b1, 1'b0};
        vecs[10] = '{0,   5,  20,  15, 4, 1'b1, 1'b0};
        vecs[11] = '{0,  36,  20, -16, 5, 1'b0, 1'b0};
        vecs[12] = '{0, 256, 300,  44, 8, 1'b1, 1'b0};
        vecs[13] = '{0,   0,   0,   0, 0, 1'b0, 1'b0};
        vecs[14] = '{0, 100, 100,   0, 0, 1'b0, 1'b0};
        vecs[15] = '{0, 100, 100,   0, 0, 1'b0, 1'b0};
        vecs[16] = '{0, 100, 100,   0, 0, 1'b0, 1'b1};
        vecs[17] = '{0, 100, 100,   0, 0, 1'b0, 1'b1};

        // Reset held with enable high must still keep everything cleared
        reset  = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) cycle_step(1'b1, rnd_tgt());
        check("rst_inc", longint'(inc), 0);
        check("rst_dec", longint'(dec), 0);
        check("rst_locked", longint'(locked), 0);
        check("rst_lastError", longint'(lastError), 0);

        reset = 1'b1;
        cycle_step(1'b1, rnd_tgt());
        for (int i = 0; i < 18; i++) run_window(vecs[i], i);

        // Enable dropped mid-MEASURE while locked
        for (int i = 0; i < 50; i++) cycle_step(i % 3 == 0, rnd_tgt());
        enable = 1'b0;
        cycle_step(1'b1, rnd_tgt());
        check("endrop_locked", longint'(locked), 0);
        check("endrop_inc", longint'(inc), 0);
        check("endrop_dec", longint'(dec), 0);
        check("endrop_lastError_hold", longint'(lastError), 0);
        for (int i = 0; i < 4; i++) cycle_step(1'b1, rnd_tgt());
        enable = 1'b1;
        cycle_step(1'b1, rnd_tgt());
        run_window('{0, 100, 100, 0, 0, 1'b0, 1'b0}, 100);

        // Enable dropped on the second pulse of an 8-pulse burst
        run_measure(0, 0, 100);
        base = cyc;
        exp_q.push_back('{is_inc: 1'b1, cyc: base});
        exp_q.push_back('{is_inc: 1'b1, cyc: base + 2});
        check("abort_lastError", longint'(lastError), 100);
        cycle_step(1'b1, rnd_tgt());
        cycle_step(1'b1, rnd_tgt());
        enable = 1'b0;
        cycle_step(1'b1, rnd_tgt());
        check("abort_inc", longint'(inc), 0);
        check("abort_dec", longint'(dec), 0);
        check("abort_locked", longint'(locked), 0);
        check("abort_lastError_hold", longint'(lastError), 100);
        check("abort_pulses", exp_q.size(), 0);
        for (int i = 0; i < 3; i++) cycle_step(1'b1, rnd_tgt());
        enable = 1'b1;
        cycle_step(1'b1, rnd_tgt());

        // Reset in the middle of a window with ticks arriving
        for (int i = 0; i < 100; i++) cycle_step(1'b1, rnd_tgt());
        reset = 1'b0;
        cycle_step(1'b1, rnd_tgt());
        check("midrst_inc", longint'(inc), 0);
        check("midrst_dec", longint'(dec), 0);
        check("midrst_locked", longint'(locked), 0);
        check("midrst_lastError", longint'(lastError), 0);
        reset = 1'b1;
        cycle_step(1'b1, rnd_tgt());
        run_window('{0, 97, 100, 3, 1, 1'b1, 1'b0}, 101);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
